// File: rtl/cnu_pkg.sv
// Shared constants and the min1/min2 result record for the check-node units.
package cnu_pkg;

  localparam int CN_DEGREE          = 6;
  localparam int QUAN_SIZE          = 3;
  localparam int MIN_INDEX_BITWIDTH = $clog2(CN_DEGREE);
  localparam int BUNDLE_W           = CN_DEGREE * QUAN_SIZE;

  typedef struct packed {
    logic [QUAN_SIZE-1:0]          m1;
    logic [QUAN_SIZE-1:0]          m2;
    logic [MIN_INDEX_BITWIDTH-1:0] min1_idx;
    logic [MIN_INDEX_BITWIDTH-1:0] min2_idx;
  } cnu_min_result_t;

endpackage

// File: rtl/cnu_min6_tree.sv
// Combinational min1/min2 finder over one six-message bundle.
module cnu_min6_tree
  import cnu_pkg::*;
(
  input  logic [BUNDLE_W-1:0] msg,
  output cnu_min_result_t     res
);

  // Strict '<' keeps the lowest position on ties, so equal inputs give m1 == m2
  // with min1_idx below min2_idx.
  always_comb begin
    logic [QUAN_SIZE-1:0] val;
    logic                 found;
    res   = '0;
    val   = '0;
    found = 1'b0;
    res.m1 = msg[QUAN_SIZE-1:0];
    for (int k = 1; k < CN_DEGREE; k++) begin
      val = msg[k*QUAN_SIZE +: QUAN_SIZE];
      if (val < res.m1) begin
        res.m1       = val;
        res.min1_idx = MIN_INDEX_BITWIDTH'(k);
      end
    end
    for (int k = 0; k < CN_DEGREE; k++) begin
      val = msg[k*QUAN_SIZE +: QUAN_SIZE];
      if ((MIN_INDEX_BITWIDTH'(k) != res.min1_idx) && (!found || (val < res.m2))) begin
        res.m2       = val;
        res.min2_idx = MIN_INDEX_BITWIDTH'(k);
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnu_min_arbiter.sv
// Round-robin share of one min1/min2 finder between NUM_REQ check-node requesters.
module cnu_min_arbiter
  import cnu_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int REQ_ID_BITWIDTH = $clog2(NUM_REQ)
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*BUNDLE_W-1:0]   req_msg,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [REQ_ID_BITWIDTH-1:0]    res_id,
  output logic [QUAN_SIZE-1:0]          res_m1,
  output logic [QUAN_SIZE-1:0]          res_m2,
  output logic [MIN_INDEX_BITWIDTH-1:0] res_min1_idx,
  output logic [MIN_INDEX_BITWIDTH-1:0] res_min2_idx
);

  // Handshake: a beat moves on the rising edge where valid & ready are both 1.
  // Producers hold valid and data stable until that edge; ready may depend
  // combinationally on valid, never the other way round.

  logic                       op_valid;
  logic [REQ_ID_BITWIDTH-1:0] op_id;
  logic [BUNDLE_W-1:0]        op_msg;
  logic [REQ_ID_BITWIDTH-1:0] rr_ptr;
  logic [REQ_ID_BITWIDTH-1:0] rr_next;
  logic [REQ_ID_BITWIDTH-1:0] grant_id;
  logic [NUM_REQ-1:0]         grant;
  logic                       grant_any;
  logic [BUNDLE_W-1:0]        grant_msg;
  logic                       s1_en;
  logic                       s2_en;
  cnu_min_result_t            min_res;

  assign s2_en = ~res_valid | res_ready;
  assign s1_en = ~op_valid | s2_en;

  always_comb begin
    int idx;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    if (s1_en && !rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(rr_ptr) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_any && req_valid[idx]) begin
          grant[idx] = 1'b1;
          grant_id   = REQ_ID_BITWIDTH'(idx);
          grant_any  = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;
  assign grant_msg = req_msg[int'(grant_id)*BUNDLE_W +: BUNDLE_W];
  assign rr_next   = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

  cnu_min6_tree u_min6_tree (
    .msg (op_msg),
    .res (min_res)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      op_valid     <= 1'b0;
      op_id        <= '0;
      op_msg       <= '0;
      rr_ptr       <= '0;
      res_valid    <= 1'b0;
      res_id       <= '0;
      res_m1       <= '0;
      res_m2       <= '0;
      res_min1_idx <= '0;
      res_min2_idx <= '0;
    end else begin
      if (s1_en) begin
        op_valid <= grant_any;
        if (grant_any) begin
          op_msg <= grant_msg;
          op_id  <= grant_id;
          rr_ptr <= rr_next;
        end
      end
      // S2 drains and S1 refills on the same edge without losing the bundle.
      if (s2_en) begin
        res_valid <= op_valid;
        if (op_valid) begin
          res_id       <= op_id;
          res_m1       <= min_res.m1;
          res_m2       <= min_res.m2;
          res_min1_idx <= min_res.min1_idx;
          res_min2_idx <= min_res.min2_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnu_min_arbiter.sv
// Directed bench for cnu_min_arbiter: cycle model of grants plus result scoreboard.
module tb_cnu_min_arbiter;
  import cnu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int RW      = IDW + 2*QUAN_SIZE + 2*MIN_INDEX_BITWIDTH;

  logic                          sys_clk;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*BUNDLE_W-1:0]   req_msg;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          res_valid;
  logic                          res_ready;
  logic [IDW-1:0]                res_id;
  logic [QUAN_SIZE-1:0]          res_m1;
  logic [QUAN_SIZE-1:0]          res_m2;
  logic [MIN_INDEX_BITWIDTH-1:0] res_min1_idx;
  logic [MIN_INDEX_BITWIDTH-1:0] res_min2_idx;

  logic [RW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          m_op_valid = 1'b0;
  logic          m_res_valid = 1'b0;
  int            m_rr = 0;

  wire [RW-1:0] res_pack = {res_id, res_m1, res_min1_idx, res_m2, res_min2_idx};

  cnu_min_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_msg      (req_msg),
    .req_ready    (req_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_id       (res_id),
    .res_m1       (res_m1),
    .res_m2       (res_m2),
    .res_min1_idx (res_min1_idx),
    .res_min2_idx (res_min2_idx)
  );

  // ---------------- clock ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- helpers ----------------
  function automatic logic [BUNDLE_W-1:0] pack6(int a0, int a1, int a2, int a3, int a4, int a5);
    logic [BUNDLE_W-1:0] b;
    b = {QUAN_SIZE'(a5), QUAN_SIZE'(a4), QUAN_SIZE'(a3), QUAN_SIZE'(a2), QUAN_SIZE'(a1), QUAN_SIZE'(a0)};
    return b;
  endfunction

  // Stable sort of (value, position) pairs; the first two entries are m1 and m2.
  function automatic logic [RW-1:0] model_res(int id, logic [BUNDLE_W-1:0] b);
    int v[CN_DEGREE];
    int ord[CN_DEGREE];
    int t;
    for (int k = 0; k < CN_DEGREE; k++) begin
      v[k]   = int'(b[k*QUAN_SIZE +: QUAN_SIZE]);
      ord[k] = k;
    end
    for (int i = 1; i < CN_DEGREE; i++) begin
      for (int j = i; j > 0 && v[ord[j]] < v[ord[j-1]]; j--) begin
        t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
      end
    end
    return {IDW'(id), QUAN_SIZE'(v[ord[0]]), MIN_INDEX_BITWIDTH'(ord[0]),
            QUAN_SIZE'(v[ord[1]]), MIN_INDEX_BITWIDTH'(ord[1])};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res_const(string tag, logic [RW-1:0] e);
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check(tag, 32'(res_pack), 32'(e));
  endtask

  task automatic set_bundle(int r, logic [BUNDLE_W-1:0] b);
    req_msg[r*BUNDLE_W +: BUNDLE_W] = b;
  endtask

  task automatic randomize_bundles();
    for (int r = 0; r < NUM_REQ; r++)
      set_bundle(r, pack6($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
  endtask

  // ---------------- driver / scoreboard cycle ----------------
  task automatic cycle();
    logic [NUM_REQ-1:0] eg;
    logic s1e, s2e;
    int g, idx;
    @(negedge sys_clk);
    s2e = !m_res_valid || res_ready;
    s1e = !m_op_valid || s2e;
    eg  = '0;
    g   = -1;
    if (s1e && !rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (m_rr + i) % NUM_REQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(eg));
    check("res_valid", 32'(res_valid), 32'(m_res_valid));
    if (m_res_valid && exp_q.size() > 0) check("res_data", 32'(res_pack), 32'(exp_q[0]));
    @(posedge sys_clk);
    if (rst) begin
      m_op_valid  = 1'b0;
      m_res_valid = 1'b0;
      m_rr        = 0;
      exp_q.delete();
    end else begin
      if (m_res_valid && res_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (s2e) m_res_valid = m_op_valid;
      if (s1e) begin
        m_op_valid = (g >= 0);
        if (g >= 0) begin
          exp_q.push_back(model_res(g, req_msg[g*BUNDLE_W +: BUNDLE_W]));
          m_rr = (g + 1) % NUM_REQ;
        end
      end
    end
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    res_ready = 1'b1;
    repeat (3) cycle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_msg   = '0;
    res_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    cycle();
    rst = 1'b0;
    #1;
    check("reset_outputs", 32'({res_valid, res_pack}), 32'd0);

    // single requester
    set_bundle(0, pack6(5, 3, 7, 3, 6, 4));
    req_valid = 4'b0001;
    #1;
    check("single_grant", 32'(req_ready), 32'b0001);
    cycle();
    req_valid = '0;
    cycle();
    #1;
    check_res_const("single_res", {2'd0, 3'd3, 3'd1, 3'd3, 3'd3});
    drain();

    // round robin, full throughput
    req_valid = 4'b1111;
    repeat (12) begin
      randomize_bundles();
      cycle();
    end
    drain();

    // backpressure
    req_valid = 4'b1111;
    res_ready = 1'b0;
    randomize_bundles();
    cycle();
    randomize_bundles();
    cycle();
    #1;
    check("bp_stall", 32'(req_ready), 32'd0);
    repeat (3) cycle();
    res_ready = 1'b1;
    repeat (4) begin
      randomize_bundles();
      cycle();
    end
    drain();

    // tie and last-position boundaries
    set_bundle(1, pack6(2, 2, 2, 2, 2, 2));
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    cycle();
    #1;
    check_res_const("all_equal", {2'd1, 3'd2, 3'd0, 3'd2, 3'd1});
    cycle();
    set_bundle(2, pack6(7, 7, 7, 7, 7, 0));
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    cycle();
    #1;
    check_res_const("last_min", {2'd2, 3'd0, 3'd5, 3'd7, 3'd0});
    drain();

    // reset with both stages occupied
    req_valid = 4'b1111;
    res_ready = 1'b0;
    randomize_bundles();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("midrst_out", 32'({res_valid, res_pack}), 32'd0);
    check("midrst_grant", 32'(req_ready), 32'b0001);
    res_ready = 1'b1;
    cycle();

    // skip idle requesters starting from rr_ptr = 2
    req_valid = 4'b0010;
    cycle();
    req_valid = 4'b1010;
    #1;
    check("skip_grant3", 32'(req_ready), 32'b1000);
    cycle();
    #1;
    check("skip_grant1", 32'(req_ready), 32'b0010);
    cycle();
    drain();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
